chien_search: RTL and testbench
===============================

# chien_search

GF(2^M) Chien-search step engine for the post-quantum BCH/ECC decoder path. It holds one field element (an error-locator term σ) in an internal register. On request it multiplies that register N times by a supplied field element (typically α^j), giving σ·α^(j·N) as one step of the Chien root search. Multiplication is digit-serial, PARAM_ALPHA multiplier bits per cycle. Accessed through a 32-bit operand/result accelerator port with a level-enable / ready handshake.

## Interface
- PARAM_M, 9: field degree M; element width in bits; legal range 2..16.
- PARAM_ALPHA, 4: digit size, i.e. multiplier bits processed per clock; legal range 1..PARAM_M.
- PARAM_POLY, 'h211: reduction polynomial including the x^M term (x^9+x^4+1).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  level request; an operation starts when enable is high while the block is idle.
- in_1  in  32  [16+M-1:16] = σ load value; [7:0] = iteration count N; all other bits ignored.
- in_2  in  32  [31] = LOAD flag; [30] = MUL flag; [16+M-1:16] = multiplier b; all other bits ignored.
- out_1  out  32  {(32-M) zeros, R}: the current element register.
- ready  out  1  result valid / operation complete.

## Operation
- States:
  - IDLE: ready=0.
  - BUSY: iterating.
  - DONE: ready=1.
- IDLE→BUSY when enable=1 is sampled.
  - On that edge, in_1 and in_2 are latched.
  - If LOAD=1, R←in_1[16+M-1:16]; otherwise R keeps its value from the previous operation.
- Work count: if MUL=1, N multiplications R←R·b mod PARAM_POLY are performed. If MUL=0 or N=0, no multiplication is performed.
- Each multiplication is MSB-first digit-serial:
  - It takes D=ceil(M/PARAM_ALPHA) cycles, consuming PARAM_ALPHA bits of b per cycle.
  - Intermediate accumulators are reduced every cycle, so no value ever exceeds M bits.
- Zero-padding: when M is not a multiple of PARAM_ALPHA, the top digit is zero-padded.
- Result: after the last multiplication, R holds the product and the FSM moves BUSY→DONE.
- DONE→IDLE on the first cycle enable is sampled low. ready stays 1 for as long as enable stays high.
- A new operation requires enable to be low for at least one cycle after DONE. Holding enable high never retriggers.
- Inputs changing during BUSY/DONE have no effect; the latched copies are used.
- Dropping enable during BUSY does not abort. The operation completes, ready=1 for exactly one cycle, then the FSM returns to IDLE.
- out_1 always reflects R. It updates only when a multiplication completes or on LOAD, and never shows partial digit sums.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, R=0, out_1=0, ready=0. This applies immediately, also mid-operation. Release is synchronous to clk.
- Latency: enable sampled at edge 0 → ready=1 after edge K·D+1, where K = N if MUL=1, else 0.
  - K=0: ready after edge 1.
  - M=9, ALPHA=4, N=1: ready after edge 4.
- out_1 is valid whenever ready=1 and holds its value in IDLE.
- Throughput: one operation per K·D+3 cycles minimum (start, compute, done, one idle-low cycle).

## Test plan
- Reset → out_1=0, ready=0; then pulse enable for 6 cycles with in_1=0x01530001, in_2=0xC1530001 → ready rises at cycle 4, out_1=0x00000149.
- Repeat the same 6-cycle pulse after 20 idle cycles → identical result 0x149, and ready falls one cycle after enable drops.
- LOAD=0 chaining: in_2=0x41530001 after the previous result → R=0x149·0x153 = out_1 0x000000A9.
- Reduction wrap: load R=0x001, b=0x002, N=9, MUL=1 → out_1=0x011 (α^9 = x^4+1), ready after 28 cycles.
- MUL=0, LOAD=1, σ=0x1FF → out_1=0x1FF, ready after 1 cycle; enable held high for 10 cycles → no retrigger, R unchanged.
- Assert rst low mid-BUSY → ready=0 and out_1=0 immediately; a subsequent operation behaves normally.

Source files
------------

// File: rtl/chien_search.sv
// GF(2^M) Chien-search step engine: R <- R * b^N, digit-serial MSB-first multiply,
// driven through a 32-bit operand/result port with a level-enable / ready handshake.
module chien_search #(
  parameter int          PARAM_M     = 9,
  parameter int          PARAM_ALPHA = 4,
  parameter logic [16:0] PARAM_POLY  = 17'h211
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  output logic [31:0] out_1,
  output logic        ready
);

  localparam int M  = PARAM_M;
  localparam int A  = PARAM_ALPHA;
  localparam int D  = (M + A - 1) / A;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = D * A;
  localparam logic [M-1:0]  POLY_LO  = PARAM_POLY[M-1:0];
  localparam logic [DW-1:0] DCNT_TOP = DW'(D - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [M-1:0]  r_q, r_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [M-1:0]  b_q, b_d;
  logic [7:0]    iter_q, iter_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [PW-1:0] b_pad;
  logic [A-1:0]  digit;
  logic [M-1:0]  acc_step;
  logic          unused_inputs;

  // Multiply by x with immediate reduction, keeping every value within M bits.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
    xtime = {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY_LO : '0);
  endfunction

  // One Horner digit: acc * x^A + r * digit, reduced after every bit.
  function automatic logic [M-1:0] digit_step(input logic [M-1:0] acc,
                                               input logic [M-1:0] r,
                                               input logic [A-1:0] dig);
    logic [M-1:0] t;
    t = acc;
    for (int k = A - 1; k >= 0; k--) begin
      t = xtime(t) ^ (dig[k] ? r : '0);
    end
    return t;
  endfunction

  always_comb begin
    b_pad          = '0;
    b_pad[M-1:0]   = b_q;
    digit          = b_pad[int'(dcnt_q) * A +: A];
    acc_step       = digit_step(acc_q, r_q, digit);
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    acc_d   = acc_q;
    b_d     = b_q;
    iter_d  = iter_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_BUSY;
          b_d     = in_2[16 +: M];
          iter_d  = in_2[30] ? in_1[7:0] : 8'd0;
          dcnt_d  = DCNT_TOP;
          acc_d   = '0;
          if (in_2[31]) begin
            r_d = in_1[16 +: M];
          end
        end
      end
      ST_BUSY: begin
        if (iter_q == 8'd0) begin
          state_d = ST_DONE;
        end else if (dcnt_q == '0) begin
          // Last digit: commit the product so out_1 never shows partial sums.
          r_d    = acc_step;
          acc_d  = '0;
          iter_d = iter_q - 8'd1;
          dcnt_d = DCNT_TOP;
        end else begin
          acc_d  = acc_step;
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      iter_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      iter_q  <= iter_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign out_1         = {{(32 - M){1'b0}}, r_q};
  assign ready         = (state_q == ST_DONE);
  assign unused_inputs = ^{in_1, in_2};

endmodule

// File: tb/tb_chien_search.sv
// Self-checking bench for chien_search: directed vectors plus randomized operations
// checked against a shift-and-reduce GF(2^9) reference model.
module tb_chien_search;

  localparam int          M    = 9;
  localparam int          A    = 4;
  localparam int          D    = (M + A - 1) / A;
  localparam logic [16:0] POLY = 17'h211;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] in_1 = '0;
  logic [31:0] in_2 = '0;
  logic [31:0] out_1;
  logic        ready;

  int checks = 0;
  int passed = 0;
  logic [M-1:0] model_r = '0;

  chien_search #(.PARAM_M(M), .PARAM_ALPHA(A), .PARAM_POLY(POLY)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_1(in_1), .in_2(in_2), .out_1(out_1), .ready(ready)
  );

  always #5 clk = ~clk;

  // Full polynomial product, then long-division reduction by POLY.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p, wa, wp;
    p = '0; wa = '0; wp = '0;
    wa[M-1:0] = a;
    wp[M:0]   = POLY[M:0];
    for (int i = 0; i < M; i++) if (b[i]) p = p ^ (wa << i);
    for (int k = 2*M - 2; k >= M; k--) if (p[k]) p = p ^ (wp << (k - M));
    return p[M-1:0];
  endfunction

  task automatic model_apply(input logic [31:0] i1, input logic [31:0] i2);
    if (i2[31]) model_r = i1[16 +: M];
    if (i2[30]) repeat (int'(i1[7:0])) model_r = gf_mul(model_r, i2[16 +: M]);
  endtask

  function automatic int exp_latency(input logic [31:0] i1, input logic [31:0] i2);
    return (i2[30] ? int'(i1[7:0]) : 0) * D + 1;
  endfunction

  // Drives one operation with enable held high, scrambles inputs while busy,
  // returns latency (edges after the start edge) or -1 on timeout.
  task automatic run_op(input logic [31:0] i1, input logic [31:0] i2,
                        output int lat, output logic [31:0] res);
    lat = -1;
    res = '0;
    in_1 = i1; in_2 = i2; enable = 1'b1;
    @(posedge clk); #1;
    in_1 = $urandom; in_2 = $urandom;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk); @(negedge clk);
      if (ready) begin
        lat = c;
        res = out_1;
        break;
      end
      in_1 = $urandom; in_2 = $urandom;
    end
    enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || out_1 !== 32'h0) $display("FAIL reset: ready=%b out_1=%h, want 0/00000000", ready, out_1);
    else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic spec_pulse(input string tag);
    int rise;
    logic [31:0] res;
    rise = -1;
    res = '0;
    @(negedge clk);
    in_1 = 32'h01530001; in_2 = 32'hC1530001; enable = 1'b1;
    model_apply(in_1, in_2);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (ready && rise < 0) begin
        rise = c;
        res  = out_1;
      end
      if (c == 5) enable = 1'b0;
    end
    checks++;
    if (rise !== 4) $display("FAIL %s_latency: ready rose after edge %0d, want 4", tag, rise);
    else passed++;
    checks++;
    if (res !== 32'h149 || res[M-1:0] !== model_r) $display("FAIL %s_result: out_1=%h, want 00000149 (model %h)", tag, res, model_r);
    else passed++;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ready !== 1'b0 || out_1 !== 32'h149) $display("FAIL %s_fall: ready=%b out_1=%h, want 0/00000149", tag, ready, out_1);
    else passed++;
    $display("op %s: latency=%0d out_1=%h", tag, rise, res);
  endtask

  task automatic test_first_pulse();
    spec_pulse("pulse1");
  endtask

  task automatic test_repeat_pulse();
    repeat (20) @(negedge clk);
    spec_pulse("pulse2");
  endtask

  task automatic test_chain();
    int lat;
    logic [31:0] res;
    @(negedge clk);
    model_apply(32'h01530001, 32'h41530001);
    run_op(32'h01530001, 32'h41530001, lat, res);
    checks++;
    if (res !== 32'hA9 || res[M-1:0] !== model_r) $display("FAIL chain_result: out_1=%h, want 000000a9", res);
    else passed++;
    checks++;
    if (lat !== 4) $display("FAIL chain_latency: %0d, want 4", lat);
    else passed++;
    $display("op chain: latency=%0d out_1=%h", lat, res);
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] res;
    @(negedge clk);
    model_apply(32'h00010009, 32'hC0020000);
    run_op(32'h00010009, 32'hC0020000, lat, res);
    checks++;
    if (res !== 32'h11 || res[M-1:0] !== model_r) $display("FAIL wrap_result: out_1=%h, want 00000011", res);
    else passed++;
    checks++;
    if (lat !== 28) $display("FAIL wrap_latency: %0d, want 28", lat);
    else passed++;
    $display("op wrap: latency=%0d out_1=%h", lat, res);
  endtask

  task automatic test_mul0_hold();
    int bad;
    bad = 0;
    @(negedge clk);
    in_1 = 32'h01FF0005; in_2 = 32'h80020000; enable = 1'b1;
    model_apply(in_1, in_2);
    @(posedge clk); @(negedge clk);
    checks++;
    if (ready !== 1'b0) $display("FAIL mul0_early: ready=%b after start edge, want 0", ready);
    else passed++;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ready !== 1'b1 || out_1 !== 32'h1FF) $display("FAIL mul0_result: ready=%b out_1=%h, want 1/000001ff", ready, out_1);
    else passed++;
    for (int c = 0; c < 10; c++) begin
      in_1 = $urandom; in_2 = $urandom | 32'hC0000000;
      @(posedge clk); @(negedge clk);
      if (ready !== 1'b1 || out_1 !== 32'h1FF) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL mul0_hold: %0d cycles with ready/out_1 disturbed, want 0", bad);
    else passed++;
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ready !== 1'b0 || out_1 !== 32'h1FF) $display("FAIL mul0_release: ready=%b out_1=%h, want 0/000001ff", ready, out_1);
    else passed++;
    $display("op mul0_hold: out_1=%h disturbed_cycles=%0d", out_1, bad);
  endtask

  task automatic test_drop_enable();
    int rise, high;
    logic [31:0] i1, i2;
    rise = -1; high = 0;
    i1 = 32'h01230003; i2 = 32'hC0470000;
    @(negedge clk);
    in_1 = i1; in_2 = i2; enable = 1'b1;
    model_apply(i1, i2);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (ready) begin
        high++;
        if (rise < 0) rise = c;
      end
    end
    checks++;
    if (rise !== exp_latency(i1, i2)) $display("FAIL drop_latency: %0d, want %0d", rise, exp_latency(i1, i2));
    else passed++;
    checks++;
    if (high !== 1 || out_1[M-1:0] !== model_r) $display("FAIL drop_ready: ready cycles=%0d out_1=%h, want 1/%h", high, out_1, model_r);
    else passed++;
    $display("op drop_enable: latency=%0d ready_cycles=%0d out_1=%h", rise, high, out_1);
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    logic [31:0] res, i1, i2;
    @(negedge clk);
    in_1 = 32'h00010009; in_2 = 32'hC0020000; enable = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0; enable = 1'b0;
    #1;
    model_r = '0;
    checks++;
    if (ready !== 1'b0 || out_1 !== 32'h0) $display("FAIL rst_mid: ready=%b out_1=%h, want 0/00000000", ready, out_1);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    i1 = {7'd0, 9'h0B7, 8'd0, 8'd2};
    i2 = {2'b11, 5'd0, 9'h1C3, 16'd0};
    model_apply(i1, i2);
    run_op(i1, i2, lat, res);
    checks++;
    if (res[M-1:0] !== model_r || lat !== exp_latency(i1, i2)) $display("FAIL rst_after: out_1=%h lat=%0d, want %h/%0d", res, lat, model_r, exp_latency(i1, i2));
    else passed++;
    $display("op after_reset: latency=%0d out_1=%h", lat, res);
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] res, i1, i2;
    for (int t = 0; t < 24; t++) begin
      i1 = $urandom;
      i1[7:0] = 8'($urandom_range(0, 12));
      i2 = $urandom;
      if (t == 0) i2[31:30] = 2'b01;
      @(negedge clk);
      model_apply(i1, i2);
      run_op(i1, i2, lat, res);
      checks++;
      if (res !== {23'd0, model_r}) $display("FAIL rand%0d_result: out_1=%h, want %h", t, res, model_r);
      else passed++;
      checks++;
      if (lat !== exp_latency(i1, i2)) $display("FAIL rand%0d_latency: %0d, want %0d", t, lat, exp_latency(i1, i2));
      else passed++;
      $display("op rand%0d: in_1=%h in_2=%h latency=%0d out_1=%h", t, i1, i2, lat, res);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_first_pulse();
    test_repeat_pulse();
    test_chain();
    test_wrap();
    test_mul0_hold();
    test_drop_enable();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
